// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 key decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
    localparam logic [7:0] BAT_OK       = 8'hAA;
    localparam logic [7:0] BAT_FAIL     = 8'hFC;
    localparam logic [7:0] ERR0         = 8'h00;
    localparam logic [7:0] ERR1         = 8'hFF;

    // Bytes of the Pause sequence that follow the leading E1.
    localparam logic [2:0] PAUSE_SKIP   = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == BAT_OK) || (b == BAT_FAIL) || (b == ERR0) || (b == ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only alongside a pop.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  ps2_event_t push_evt,
    input  logic       pop,
    output ps2_event_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    ps2_event_t  r_mem [FIFO_DEPTH];
    logic        w_do_pop;
    logic        w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage; cleared on reset so an empty FIFO presents an all-zero head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_evt;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Assembles Set-2 prefix sequences into key events and queues them for the system.
// Optional PS2_MODIFIER_TRACK_EN adds the mods[7:0] modifier-state output.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_code,
    input  logic                 rx_parity_err,
    input  logic                 rx_frame_err,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [7:0]           evt_code,
    output logic                 evt_ext,
    output logic                 evt_break,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 stat_clr,
    output logic [7:0]           dev_status
`ifdef PS2_MODIFIER_TRACK_EN
    ,
    output logic [7:0]           mods
`endif
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    ps2_state_e           r_state;
    ps2_state_e           w_state_nxt;
    logic [2:0]           r_skip;
    logic [2:0]           w_skip_nxt;
    logic                 w_push;
    ps2_event_t           w_push_evt;
    logic                 w_status_we;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    ps2_event_t           w_head;
    logic                 r_overflow;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [7:0]           r_dev_status;

    assign w_bad  = rx_valid && (rx_parity_err || rx_frame_err);
    assign w_good = rx_valid && !rx_parity_err && !rx_frame_err;

    // State and Pause skip-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Prefix decode: next state and the event to push for this byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_skip_nxt      = r_skip;
        w_push          = 1'b0;
        w_status_we     = 1'b0;
        w_push_evt.code = rx_code;
        w_push_evt.ext  = 1'b0;
        w_push_evt.brk  = 1'b0;
        if (w_bad) begin
            w_state_nxt = ST_IDLE;
        end else if (w_good) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_code == PREFIX_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (rx_code == PREFIX_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (rx_code == PREFIX_PAUSE) begin
                        w_state_nxt = ST_PAUSE;
                        w_skip_nxt  = PAUSE_SKIP;
                    end else if (is_status_byte(rx_code)) begin
                        w_status_we = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_code == PREFIX_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (rx_code == PREFIX_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_push         = 1'b1;
                        w_push_evt.ext = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_push         = 1'b1;
                    w_push_evt.brk = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_push         = 1'b1;
                    w_push_evt.ext = 1'b1;
                    w_push_evt.brk = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (r_skip == 3'd1) begin
                        w_push          = 1'b1;
                        w_push_evt.code = PREFIX_PAUSE;
                        w_push_evt.ext  = 1'b1;
                        w_skip_nxt      = 3'd0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_skip_nxt = r_skip - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign evt_valid = !w_empty;
    assign w_pop     = evt_valid && evt_ready;

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_evt (w_push_evt),
        .pop      (w_pop),
        .head     (w_head),
        .empty    (w_empty),
        .full     (w_full)
    );

    assign evt_code  = w_head.code;
    assign evt_ext   = w_head.ext;
    assign evt_break = w_head.brk;

    // Status: saturating error count and sticky overflow; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (stat_clr) begin
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_bad && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_ONE;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Last device status byte seen while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dev_status <= 8'h00;
        end else if (w_status_we) begin
            r_dev_status <= rx_code;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign overflow   = r_overflow;
    assign dev_status = r_dev_status;

`ifdef PS2_MODIFIER_TRACK_EN
    logic [7:0] r_mods;

    // Returns {hit, bit index} for a modifier key; fake-shift E0 12/E0 59 never hits.
    function automatic logic [3:0] mod_index(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h012:  return 4'b1000;
            9'h059:  return 4'b1001;
            9'h014:  return 4'b1010;
            9'h114:  return 4'b1011;
            9'h011:  return 4'b1100;
            9'h111:  return 4'b1101;
            9'h11F:  return 4'b1110;
            9'h127:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    logic [3:0] w_mod_hit;
    assign w_mod_hit = mod_index(w_push_evt.ext, w_push_evt.code);

    // Modifier state follows generated events whether or not the FIFO accepts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mods <= 8'h00;
        end else if (w_push && w_mod_hit[3]) begin
            r_mods[w_mod_hit[2:0]] <= !w_push_evt.brk;
        end
    end

    assign mods = r_mods;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: constant vector table, directed corner cases, randomized run vs. reference model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_code;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       stat_clr;
    logic [7:0] dev_status;
`ifdef PS2_MODIFIER_TRACK_EN
    logic [7:0] mods;
`endif

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(8), .ERR_CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_code       (rx_code),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_ext       (evt_ext),
        .evt_break     (evt_break),
        .overflow      (overflow),
        .err_cnt       (err_cnt),
        .stat_clr      (stat_clr),
        .dev_status    (dev_status)
`ifdef PS2_MODIFIER_TRACK_EN
        ,
        .mods          (mods)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending good bytes since the last event, plus an event queue.
    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        mq[$];
    logic [7:0] pend[$];
    int         m_err;
    logic       m_ovf;
    logic [7:0] m_dev;

    typedef struct {
        logic [7:0] code;
        logic       perr;
        logic       exp_v;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_brk;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic model_clear();
        mq.delete();
        pend.delete();
        m_err = 0;
        m_ovf = 1'b0;
        m_dev = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic bad,
                              input logic ready, input logic clr);
        logic pop;
        logic emit;
        logic ovf_set;
        ev_t  ev;
        int   n_e0;
        int   n_f0;
        pop     = (mq.size() > 0) && ready;
        emit    = 1'b0;
        ovf_set = 1'b0;
        ev      = '{8'h00, 1'b0, 1'b0};
        n_e0    = 0;
        n_f0    = 0;
        foreach (pend[k]) begin
            if (pend[k] == 8'hE0) n_e0++;
            if (pend[k] == 8'hF0) n_f0++;
        end
        if (v && bad) begin
            pend.delete();
            if (m_err < 255) m_err++;
        end else if (v) begin
            if (pend.size() > 0 && pend[0] == 8'hE1) begin
                pend.push_back(b);
                if (pend.size() == 8) begin
                    emit = 1'b1;
                    ev   = '{8'hE1, 1'b1, 1'b0};
                    pend.delete();
                end
            end else if (pend.size() == 0 && b == 8'hE1) begin
                pend.push_back(b);
            end else if ((b == 8'hF0 || b == 8'hE0) && n_f0 == 0) begin
                pend.push_back(b);
            end else if (pend.size() == 0 && is_status(b)) begin
                m_dev = b;
            end else begin
                emit = 1'b1;
                ev   = '{b, n_e0 > 0, n_f0 > 0};
                pend.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (emit) begin
            if (mq.size() < 8) mq.push_back(ev);
            else ovf_set = 1'b1;
        end
        if (clr) begin
            m_err = 0;
            m_ovf = 1'b0;
        end else if (ovf_set) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("evt_valid", int'(evt_valid), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("evt_code", int'(evt_code), int'(mq[0].code));
            chk("evt_ext", int'(evt_ext), int'(mq[0].ext));
            chk("evt_break", int'(evt_break), int'(mq[0].brk));
        end
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("err_cnt", int'(err_cnt), m_err);
        chk("dev_status", int'(dev_status), int'(dev_status == m_dev ? dev_status : m_dev));
    endtask

    // Drive one clock cycle of inputs, advance the model, and check 1 time unit after the edge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic pe, input logic fe,
                         input logic ready, input logic clr);
        rx_valid      = v;
        rx_code       = b;
        rx_parity_err = pe;
        rx_frame_err  = fe;
        evt_ready     = ready;
        stat_clr      = clr;
        model_step(v, b, pe || fe, ready, clr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rx_valid      = 1'b0;
        rx_code       = 8'h00;
        rx_parity_err = 1'b0;
        rx_frame_err  = 1'b0;
        evt_ready     = 1'b0;
        stat_clr      = 1'b0;
        rst_n         = 1'b0;
        model_clear();
        #20;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_code", int'(evt_code), 0);
        chk("rst_evt_ext", int'(evt_ext), 0);
        chk("rst_evt_break", int'(evt_break), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_dev_status", int'(dev_status), 0);
    endtask

    initial begin
        int n_seen;
        @(posedge clk);
        #1;
        do_reset();
        check_reset_state();

        // Table: ready held high so each event is popped by the following byte.
        tbl.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1});
        tbl.push_back('{8'hE1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h14, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hE1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h14, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h77, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 1'b0, 1'b1, 8'h75, 1'b0, 1'b0});
        tbl.push_back('{8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b1});

        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].code, tbl[i].perr, 1'b0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("tbl%0d_code", i), int'(evt_code), int'(tbl[i].exp_code));
                chk($sformatf("tbl%0d_ext", i), int'(evt_ext), int'(tbl[i].exp_ext));
                chk($sformatf("tbl%0d_brk", i), int'(evt_break), int'(tbl[i].exp_brk));
            end
        end
        chk("tbl_err_cnt", int'(err_cnt), 1);
        chk("tbl_dev_status", int'(dev_status), 8'hAA);

        // Error counter saturates.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 8'h33, i[0], !i[0], 1'b1, 1'b0);
        end
        chk("err_sat", int'(err_cnt), 8'hFF);

        // Overflow: nine makes with no consumer, first eight kept in order.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 8'h15 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_set", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_order%0d", i), int'(evt_code), 8'h15 + i);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("ovf_drained", int'(evt_valid), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_err", int'(err_cnt), 0);

        // Push and pop together while full keeps eight entries and no overflow.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full_pp_ovf", int'(overflow), 0);
        chk("full_pp_head", int'(evt_code), 8'h22);
        n_seen = 0;
        for (int i = 0; i < 12 && evt_valid; i++) begin
            n_seen++;
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("full_pp_count", n_seen, 8);

        // Reset mid-prefix drops the E0.
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check_reset_state();
        cycle(1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_ext", int'(evt_ext), 0);
        chk("rst_mid_code", int'(evt_code), 8'h75);

`ifdef PS2_MODIFIER_TRACK_EN
        do_reset();
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mods_lshift", int'(mods), 8'h01);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mods_rctrl", int'(mods), 8'h09);
        cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mods_fake", int'(mods), 8'h09);
        cycle(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mods_release", int'(mods), 8'h08);
`endif

        // Randomized traffic with stalls, errors and occasional clears.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            int         sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'hE1;
                3:       b = (($urandom & 1) != 0) ? 8'hAA : 8'hFC;
                default: b = 8'($urandom);
            endcase
            cycle(($urandom_range(0, 2) != 0), b,
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
                  ((i / 150) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
